alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage.sv | 91 +++++++++
 tb/tb_alu_issue_stage.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes R/I-type ALU instructions into a two-entry skid-buffered issue register
module alu_issue_stage (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [31:0] imm_i,
  input  logic [4:0]  rd_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [3:0]  ope_o,
  output logic        invert_o,
  output logic [4:0]  rd_o,
  output logic        illegal_o
);
  localparam int W = 75;
  logic [W-1:0] dec, main_q, main_d, skid_q, skid_d;
  logic main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic is_r, is_i, shift, alt, f7_ok, bad, inv, acc;
  logic [3:0] ope;
  logic [31:0] b;
  always_comb begin
    is_r  = opcode_i == 7'b0110011;
    is_i  = opcode_i == 7'b0010011;
    shift = is_i && funct3_i[1:0] == 2'b01;
    alt   = funct7_i == 7'b0100000;
    f7_ok = funct7_i == 7'b0000000 || alt;
    // funct7 is only an opcode extension for R-type and I-type shifts; elsewhere it is immediate bits
    bad   = !(is_r || is_i) || ((is_r || shift) &&
            (!f7_ok || (alt && funct3_i != 3'b101 && !(is_r && funct3_i == 3'b000))));
    case (funct3_i)
      3'b000:  ope = (is_r && funct7_i[5]) ? 4'b0101 : 4'b0000;
      3'b001:  ope = 4'b1001;
      3'b010:  ope = 4'b0110;
      3'b011:  ope = 4'b0100;
      3'b100:  ope = 4'b0010;
      3'b101:  ope = funct7_i[5] ? 4'b1000 : 4'b1010;
      3'b110:  ope = 4'b0011;
      default: ope = 4'b0001;
    endcase
    inv = ope == 4'b0101 || ope == 4'b0110 || ope == 4'b0100;
    b   = is_r ? rs2_data_i : shift ? {27'b0, imm_i[4:0]} : imm_i;
    dec = bad ? {1'b1, 74'b0} : {1'b0, rd_i, inv, ope, b, rs1_data_i};
  end
  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    acc      = in_valid_i && !skid_v_q;
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || out_ready_i) begin
      main_v_d = skid_v_q || acc;
      if (skid_v_q) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end else if (acc) begin
        main_d = dec;
      end
    end else if (acc) begin
      skid_v_d = 1'b1;
      skid_d   = dec;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end
  assign {illegal_o, rd_o, invert_o, ope_o, b_o, a_o} = main_q;
  assign out_valid_o = main_v_q;
  assign in_ready_o  = !skid_v_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vectors pushed to a scoreboard queue, popped by a negedge monitor
module tb_alu_issue_stage;
  logic        clk = 1'b0, rst_ni = 1'b0;
  logic        in_valid_i = 1'b0, flush_i = 1'b0, out_ready_i = 1'b0;
  logic        in_ready_o, out_valid_o, invert_o, illegal_o;
  logic [6:0]  opcode_i = '0, funct7_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] rs1_data_i = '0, rs2_data_i = '0, imm_i = '0, a_o, b_o;
  logic [4:0]  rd_i = '0, rd_o;
  logic [3:0]  ope_o;
  logic [74:0] q[$];
  logic [74:0] act, exp_a, exp_b;
  int checks = 0, errors = 0;

  alu_issue_stage dut (
    .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i), .rd_i(rd_i),
    .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .a_o(a_o), .b_o(b_o), .ope_o(ope_o), .invert_o(invert_o), .rd_o(rd_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;
  assign act = {illegal_o, rd_o, invert_o, ope_o, b_o, a_o};

  function automatic logic [74:0] e(input logic il, input logic [4:0] rd, input logic iv,
                                    input logic [3:0] op, input logic [31:0] b, input logic [31:0] a);
    return {il, rd, iv, op, b, a};
  endfunction

  task automatic chk(input string nm, input logic [74:0] got, input logic [74:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // Leaves in_valid_i high so consecutive calls stream one item per cycle
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                      input logic [4:0] rd, input logic [74:0] want);
    int n = 0;
    opcode_i = op; funct3_i = f3; funct7_i = f7;
    rs1_data_i = r1; rs2_data_i = r2; imm_i = im; rd_i = rd;
    in_valid_i = 1'b1;
    while (!in_ready_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready_o) begin
      chk("send_timeout", {74'b0, in_ready_o}, 75'd1);
      in_valid_i = 1'b0;
    end else begin
      q.push_back(want);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    in_valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_ni && out_valid_o && out_ready_i) begin
      if (q.size() == 0) chk("unexpected_issue", act, 75'bx);
      else chk("issue", act, q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("reset_valid", {73'b0, out_valid_o, in_ready_o}, 75'b01);
    chk("reset_outputs", act, 75'b0);
    #5 rst_ni = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    send(7'b0110011, 3'b000, 7'b0100000, 32'd10, 32'd3, 32'd0, 5'd5, e(0, 5, 1, 4'b0101, 32'd3, 32'd10));
    chk("rsub_latency", {74'b0, out_valid_o}, 75'd1);
    chk("rsub_fields", act, e(0, 5, 1, 4'b0101, 32'd3, 32'd10));
    send(7'b0010011, 3'b101, 7'b0100000, 32'h8000_0000, 32'd0, 32'h0000_0404, 5'd6,
         e(0, 6, 0, 4'b1000, 32'd4, 32'h8000_0000));
    send(7'b0110011, 3'b000, 7'b0000000, 32'd7, 32'd9, 32'd0, 5'd1, e(0, 1, 0, 4'b0000, 32'd9, 32'd7));
    send(7'b0110011, 3'b010, 7'b0000000, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd2,
         e(0, 2, 1, 4'b0110, 32'd1, 32'hFFFF_FFFF));
    send(7'b0010011, 3'b011, 7'b0000000, 32'd5, 32'd0, 32'h0000_0123, 5'd3,
         e(0, 3, 1, 4'b0100, 32'h0000_0123, 32'd5));
    send(7'b0010011, 3'b100, 7'b0000000, 32'hFF, 32'd0, 32'hF0, 5'd4, e(0, 4, 0, 4'b0010, 32'hF0, 32'hFF));
    send(7'b0110011, 3'b110, 7'b0000000, 32'h0F, 32'hF0, 32'd0, 5'd8, e(0, 8, 0, 4'b0011, 32'hF0, 32'h0F));
    send(7'b0010011, 3'b111, 7'b0000000, 32'h1234, 32'd0, 32'hFFFF_FFF0, 5'd9,
         e(0, 9, 0, 4'b0001, 32'hFFFF_FFF0, 32'h1234));
    send(7'b0110011, 3'b001, 7'b0000000, 32'd1, 32'd31, 32'd0, 5'd10, e(0, 10, 0, 4'b1001, 32'd31, 32'd1));
    send(7'b0010011, 3'b101, 7'b0000000, 32'h80, 32'd0, 32'h1F, 5'd11, e(0, 11, 0, 4'b1010, 32'd31, 32'h80));
    send(7'b0010011, 3'b001, 7'b0000000, 32'd2, 32'd0, 32'h23, 5'd12, e(0, 12, 0, 4'b1001, 32'd3, 32'd2));
    send(7'b0110011, 3'b101, 7'b0100000, 32'hF000_0000, 32'd2, 32'd0, 5'd13,
         e(0, 13, 0, 4'b1000, 32'd2, 32'hF000_0000));
    send(7'b0000011, 3'b000, 7'b0000000, 32'h55, 32'h66, 32'h77, 5'd7, e(1, 0, 0, 4'b0000, 32'd0, 32'd0));
    send(7'b0110011, 3'b000, 7'b0000001, 32'h55, 32'h66, 32'h77, 5'd7, e(1, 0, 0, 4'b0000, 32'd0, 32'd0));
    send(7'b0110011, 3'b100, 7'b0100000, 32'h55, 32'h66, 32'h77, 5'd7, e(1, 0, 0, 4'b0000, 32'd0, 32'd0));
    send(7'b0010011, 3'b001, 7'b0100000, 32'h55, 32'h66, 32'h77, 5'd7, e(1, 0, 0, 4'b0000, 32'd0, 32'd0));
    send(7'b0010011, 3'b101, 7'b0000001, 32'h55, 32'h66, 32'h77, 5'd7, e(1, 0, 0, 4'b0000, 32'd0, 32'd0));
    idle(3);
    chk("drained", {74'b0, out_valid_o}, 75'd0);
    // Backpressure: A sits in main, B in skid, then both drain on consecutive edges
    out_ready_i = 1'b0;
    exp_a = e(0, 14, 0, 4'b0000, 32'd2, 32'd1);
    exp_b = e(0, 15, 0, 4'b0010, 32'd4, 32'd3);
    send(7'b0110011, 3'b000, 7'b0000000, 32'd1, 32'd2, 32'd0, 5'd14, exp_a);
    send(7'b0110011, 3'b100, 7'b0000000, 32'd3, 32'd4, 32'd0, 5'd15, exp_b);
    in_valid_i = 1'b0;
    chk("bp_ready_low", {73'b0, out_valid_o, in_ready_o}, 75'b10);
    chk("bp_hold_a", act, exp_a);
    idle(2);
    chk("bp_still_a", act, exp_a);
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("bp_b_next", {act, out_valid_o, in_ready_o} >> 2, exp_b);
    chk("bp_ready_back", {73'b0, out_valid_o, in_ready_o}, 75'b11);
    @(posedge clk); #1;
    chk("bp_empty", {74'b0, out_valid_o}, 75'd0);
    // Flush with both entries full and a simultaneous input
    out_ready_i = 1'b0;
    send(7'b0110011, 3'b000, 7'b0000000, 32'd21, 32'd22, 32'd0, 5'd21, e(0, 21, 0, 4'b0000, 32'd22, 32'd21));
    send(7'b0110011, 3'b000, 7'b0000000, 32'd23, 32'd24, 32'd0, 5'd22, e(0, 22, 0, 4'b0000, 32'd24, 32'd23));
    rs1_data_i = 32'd99; rd_i = 5'd23; in_valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; in_valid_i = 1'b0;
    chk("flush_state", {73'b0, out_valid_o, in_ready_o}, 75'b01);
    q.delete();
    out_ready_i = 1'b1;
    idle(4);
    // Asynchronous reset between edges with an item held on the outputs
    out_ready_i = 1'b0;
    send(7'b0110011, 3'b110, 7'b0000000, 32'd31, 32'd32, 32'd0, 5'd30, e(0, 30, 0, 4'b0011, 32'd32, 32'd31));
    in_valid_i = 1'b0;
    chk("pre_reset_valid", {74'b0, out_valid_o}, 75'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_reset_valid", {73'b0, out_valid_o, in_ready_o}, 75'b01);
    chk("async_reset_outputs", act, 75'b0);
    q.delete();
    @(posedge clk); #3;
    rst_ni = 1'b1;
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    send(7'b0110011, 3'b111, 7'b0000000, 32'hAA, 32'h0F, 32'd0, 5'd31, e(0, 31, 0, 4'b0001, 32'h0F, 32'hAA));
    chk("post_reset_issue", {74'b0, out_valid_o}, 75'd1);
    idle(3);
    chk("queue_empty", 75'(q.size()), 75'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
